// File: rtl/wheel_state_buffer.sv
// Authoritative wheel node position/velocity store. It sequences one updater pass per
// timestep, collects the streamed results in a shadow bank and commits them atomically.
module wheel_state_buffer #(
    parameter int unsigned NUM_NODES     = 8,
    parameter int unsigned POSITION_SIZE = 16,
    parameter int unsigned VELOCITY_SIZE = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            step_in,
    input  logic signed [POSITION_SIZE-1:0] init_nodes     [2][NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] node_in_x,
    input  logic signed [POSITION_SIZE-1:0] node_in_y,
    input  logic                            node_in_valid,
    input  logic signed [VELOCITY_SIZE-1:0] vel_in_x,
    input  logic signed [VELOCITY_SIZE-1:0] vel_in_y,
    input  logic                            vel_in_valid,
    input  logic                            done_in,
    output logic signed [POSITION_SIZE-1:0] nodes_out      [2][NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] velocities_out [2][NUM_NODES],
    output logic                            begin_out,
    output logic                            busy_out,
    output logic                            frame_done_out,
    output logic                            error_out,
    output logic [7:0]                      dropped_out
);

    localparam int unsigned     CntW    = $clog2(NUM_NODES) + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(NUM_NODES);

    typedef enum logic [1:0] {StIdle, StRun, StCommit} state_e;

    state_e state_q, state_d;

    logic signed [POSITION_SIZE-1:0] nodes_q        [2][NUM_NODES];
    logic signed [POSITION_SIZE-1:0] nodes_d        [2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] vel_q          [2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] vel_d          [2][NUM_NODES];
    logic signed [POSITION_SIZE-1:0] shadow_nodes_q [2][NUM_NODES];
    logic signed [POSITION_SIZE-1:0] shadow_nodes_d [2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] shadow_vel_q   [2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] shadow_vel_d   [2][NUM_NODES];

    logic [CntW-1:0] node_cnt_q, node_cnt_d;
    logic [CntW-1:0] vel_cnt_q, vel_cnt_d;
    logic            ovf_q, ovf_d;
    logic            begin_q, begin_d;
    logic            frame_done_q, frame_done_d;
    logic            error_q, error_d;
    logic [7:0]      dropped_q, dropped_d;
    logic            commit_ok;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (step_in) state_d = StRun;
            StRun:    if (done_in) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        shadow_nodes_d = shadow_nodes_q;
        shadow_vel_d   = shadow_vel_q;
        nodes_d        = nodes_q;
        vel_d          = vel_q;
        node_cnt_d     = node_cnt_q;
        vel_cnt_d      = vel_cnt_q;
        ovf_d          = ovf_q;
        begin_d        = 1'b0;
        frame_done_d   = 1'b0;
        error_d        = error_q;
        dropped_d      = dropped_q;
        commit_ok      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (step_in) begin
                    begin_d    = 1'b1;
                    node_cnt_d = '0;
                    vel_cnt_d  = '0;
                    ovf_d      = 1'b0;
                end
            end
            StRun: begin
                if (node_in_valid) begin
                    if (node_cnt_q == CntFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_NODES; i++) begin
                            if (node_cnt_q == CntW'(i)) begin
                                shadow_nodes_d[0][i] = node_in_x;
                                shadow_nodes_d[1][i] = node_in_y;
                            end
                        end
                        node_cnt_d = node_cnt_q + 1'b1;
                    end
                end
                if (vel_in_valid) begin
                    if (vel_cnt_q == CntFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_NODES; i++) begin
                            if (vel_cnt_q == CntW'(i)) begin
                                shadow_vel_d[0][i] = vel_in_x;
                                shadow_vel_d[1][i] = vel_in_y;
                            end
                        end
                        vel_cnt_d = vel_cnt_q + 1'b1;
                    end
                end
                // Judge the frame on next-state values so a beat coincident with done counts,
                // and commit on this edge so the new state is visible during COMMIT.
                if (done_in) begin
                    commit_ok = (node_cnt_d == CntFull) && (vel_cnt_d == CntFull) && !ovf_d;
                    if (commit_ok) begin
                        nodes_d      = shadow_nodes_d;
                        vel_d        = shadow_vel_d;
                        frame_done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (step_in && (state_q != StIdle) && (dropped_q != 8'hff)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            nodes_q        <= init_nodes;
            vel_q          <= '{default: '0};
            shadow_nodes_q <= '{default: '0};
            shadow_vel_q   <= '{default: '0};
            node_cnt_q     <= '0;
            vel_cnt_q      <= '0;
            ovf_q          <= 1'b0;
            begin_q        <= 1'b0;
            frame_done_q   <= 1'b0;
            error_q        <= 1'b0;
            dropped_q      <= '0;
        end else begin
            nodes_q        <= nodes_d;
            vel_q          <= vel_d;
            shadow_nodes_q <= shadow_nodes_d;
            shadow_vel_q   <= shadow_vel_d;
            node_cnt_q     <= node_cnt_d;
            vel_cnt_q      <= vel_cnt_d;
            ovf_q          <= ovf_d;
            begin_q        <= begin_d;
            frame_done_q   <= frame_done_d;
            error_q        <= error_d;
            dropped_q      <= dropped_d;
        end
    end

    always_comb begin
        nodes_out      = nodes_q;
        velocities_out = vel_q;
        begin_out      = begin_q;
        busy_out       = (state_q != StIdle);
        frame_done_out = frame_done_q;
        error_out      = error_q;
        dropped_out    = dropped_q;
    end

endmodule

// File: tb/tb_wheel_state_buffer.sv
// Bench for wheel_state_buffer: queue-based frame model checked every cycle, plus
// literal expectations at the key cycles of each scenario.
module tb_wheel_state_buffer;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_in, step_in, node_in_valid, vel_in_valid, done_in;
    logic signed [15:0] node_in_x, node_in_y, vel_in_x, vel_in_y;
    logic signed [15:0] init_nodes     [2][N];
    logic signed [15:0] nodes_out      [2][N];
    logic signed [15:0] velocities_out [2][N];
    logic               begin_out, busy_out, frame_done_out, error_out;
    logic [7:0]         dropped_out;

    int total = 0;
    int bad   = 0;
    int begin_cnt = 0;

    wheel_state_buffer #(
        .NUM_NODES    (N),
        .POSITION_SIZE(16),
        .VELOCITY_SIZE(16)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .step_in       (step_in),
        .init_nodes    (init_nodes),
        .node_in_x     (node_in_x),
        .node_in_y     (node_in_y),
        .node_in_valid (node_in_valid),
        .vel_in_x      (vel_in_x),
        .vel_in_y      (vel_in_y),
        .vel_in_valid  (vel_in_valid),
        .done_in       (done_in),
        .nodes_out     (nodes_out),
        .velocities_out(velocities_out),
        .begin_out     (begin_out),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out),
        .error_out     (error_out),
        .dropped_out   (dropped_out)
    );

    // Model: a frame is whatever beats arrive between an accepted step and done;
    // it commits only if exactly N of each kind were seen.
    int                 m_ph;  // 0 idle, 1 collecting, 2 commit cycle
    logic signed [15:0] qnx[$], qny[$], qvx[$], qvy[$];
    logic signed [15:0] m_nodes [2][N];
    logic signed [15:0] m_vel   [2][N];
    bit                 m_begin, m_fd, m_err, chk_en;
    int                 m_drop;

    task automatic model_step();
        int ph_was;
        ph_was = m_ph;
        if (rst_in) begin
            for (int i = 0; i < N; i++) begin
                m_nodes[0][i] = init_nodes[0][i];
                m_nodes[1][i] = init_nodes[1][i];
                m_vel[0][i]   = 16'sd0;
                m_vel[1][i]   = 16'sd0;
            end
            m_ph = 0; m_begin = 0; m_fd = 0; m_err = 0; m_drop = 0;
            qnx.delete(); qny.delete(); qvx.delete(); qvy.delete();
            chk_en = 1;
        end else begin
            m_begin = 0;
            m_fd    = 0;
            if (step_in && ph_was != 0 && m_drop < 255) m_drop++;
            if (ph_was == 0 && step_in) begin
                m_begin = 1;
                m_ph    = 1;
                qnx.delete(); qny.delete(); qvx.delete(); qvy.delete();
            end else if (ph_was == 1) begin
                if (node_in_valid) begin qnx.push_back(node_in_x); qny.push_back(node_in_y); end
                if (vel_in_valid)  begin qvx.push_back(vel_in_x);  qvy.push_back(vel_in_y);  end
                if (done_in) begin
                    if (qnx.size() == N && qvx.size() == N) begin
                        for (int i = 0; i < N; i++) begin
                            m_nodes[0][i] = qnx[i];
                            m_nodes[1][i] = qny[i];
                            m_vel[0][i]   = qvx[i];
                            m_vel[1][i]   = qvy[i];
                        end
                        m_fd = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_ph = 2;
                end
            end else if (ph_was == 2) begin
                m_ph = 0;
            end
        end
    endtask

    task automatic cmp(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                cmp($sformatf("nodes_out[%0d][%0d]", k, i), nodes_out[k][i], m_nodes[k][i]);
                cmp($sformatf("velocities_out[%0d][%0d]", k, i), velocities_out[k][i],
                    m_vel[k][i]);
            end
        end
        cmp("begin_out", begin_out, m_begin);
        cmp("busy_out", busy_out, m_ph != 0);
        cmp("frame_done_out", frame_done_out, m_fd);
        cmp("error_out", error_out, m_err);
        cmp("dropped_out", dropped_out, m_drop);
        if (begin_out === 1'b1) begin_cnt++;
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); if (chk_en) compare_all(); end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic nx_cyc();
        @(negedge clk);
        step_in = 0; node_in_valid = 0; vel_in_valid = 0; done_in = 0;
    endtask

    task automatic do_reset();
        nx_cyc(); rst_in = 1;
        nx_cyc();
        nx_cyc(); rst_in = 0;
    endtask

    // Returns in the cycle carrying done_in; one node and one velocity beat per cycle.
    task automatic frame(input int nn, input int nv, input int xb, input int vb,
                         input bit done_last);
        int n = 0;
        int v = 0;
        nx_cyc(); step_in = 1;
        nx_cyc();
        while (n < nn || v < nv) begin
            nx_cyc();
            if (n < nn) begin
                node_in_valid = 1; node_in_x = 16'(xb + n); node_in_y = 16'(-(xb + n)); n++;
            end
            if (v < nv) begin
                vel_in_valid = 1; vel_in_x = 16'(vb + v); vel_in_y = 16'(vb - v); v++;
            end
            if (done_last && n == nn && v == nv) done_in = 1;
        end
        if (!done_last) begin nx_cyc(); done_in = 1; end
    endtask

    initial begin
        int hits;
        rst_in = 1; step_in = 0; node_in_valid = 0; vel_in_valid = 0; done_in = 0;
        node_in_x = 0; node_in_y = 0; vel_in_x = 0; vel_in_y = 0;
        for (int i = 0; i < N; i++) begin
            init_nodes[0][i] = 16'(i * 100);
            init_nodes[1][i] = 16'(-i);
        end

        // Reset load
        do_reset();
        cmp("lit_reset_x3", nodes_out[0][3], 300);
        cmp("lit_reset_y3", nodes_out[1][3], -3);
        cmp("lit_reset_vel", velocities_out[0][5], 0);
        cmp("lit_reset_busy", busy_out, 0);

        // Nominal frame: interleaved streams with gaps, done 30 cycles after the step
        nx_cyc(); step_in = 1;
        nx_cyc();
        cmp("lit_begin_hi", begin_out, 1);
        cmp("lit_busy_hi", busy_out, 1);
        for (int o = 2; o <= 30; o++) begin
            nx_cyc();
            cmp("lit_begin_lo", begin_out, 0);
            if (o <= 16 && o % 2 == 0) begin
                node_in_valid = 1;
                node_in_x = 16'(1000 + (o - 2) / 2);
                node_in_y = 16'(2000 + (o - 2) / 2);
            end
            if (o >= 3 && o <= 24 && o % 3 == 0) begin
                vel_in_valid = 1;
                vel_in_x = 16'(-5 * ((o - 3) / 3));
                vel_in_y = 16'(7 * ((o - 3) / 3));
            end
            if (o == 30) begin
                cmp("lit_hold_x1", nodes_out[0][1], 100);
                done_in = 1;
            end
        end
        nx_cyc();
        cmp("lit_fd_hi", frame_done_out, 1);
        cmp("lit_new_x1", nodes_out[0][1], 1001);
        cmp("lit_new_y7", nodes_out[1][7], 2007);
        cmp("lit_new_vx7", velocities_out[0][7], -35);
        cmp("lit_new_vy2", velocities_out[1][2], 14);
        cmp("lit_busy_commit", busy_out, 1);
        nx_cyc();
        cmp("lit_busy_lo", busy_out, 0);
        cmp("lit_fd_lo", frame_done_out, 0);

        // Short stream
        frame(7, 8, 500, 40, 0);
        nx_cyc();
        cmp("lit_short_fd", frame_done_out, 0);
        cmp("lit_short_err", error_out, 1);
        cmp("lit_short_keep", nodes_out[0][1], 1001);
        nx_cyc();

        // Overflow: ninth node beat carries 7777
        do_reset();
        frame(9, 8, 7769, 60, 0);
        nx_cyc();
        cmp("lit_ovf_err", error_out, 1);
        cmp("lit_ovf_fd", frame_done_out, 0);
        hits = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                if (nodes_out[k][i] == 16'sd7777 || nodes_out[k][i] == -16'sd7777) hits++;
        cmp("lit_ovf_absent", hits, 0);
        nx_cyc();

        // Steps while busy, then saturation
        do_reset();
        begin_cnt = 0;
        nx_cyc(); step_in = 1;
        for (int o = 1; o <= 7; o++) begin
            nx_cyc();
            if (o >= 2 && o <= 4) step_in = 1;
            if (o == 6) done_in = 1;
        end
        cmp("lit_drop3", dropped_out, 3);
        for (int w = 0; w < 25; w++) begin
            nx_cyc(); step_in = 1;
            for (int o = 1; o <= 12; o++) begin
                nx_cyc(); step_in = 1;
                if (o == 11) done_in = 1;
            end
            nx_cyc();
            if (w == 9) cmp("lit_drop123", dropped_out, 123);
        end
        cmp("lit_drop_sat", dropped_out, 255);
        nx_cyc();
        cmp("lit_begin_count", begin_cnt, 26);

        // Final node beat coincident with done, then a step two cycles after done
        frame(8, 8, 3000, -100, 1);
        nx_cyc();
        cmp("lit_edge_fd", frame_done_out, 1);
        cmp("lit_edge_x7", nodes_out[0][7], 3007);
        nx_cyc(); step_in = 1;
        nx_cyc();
        cmp("lit_step_d2", begin_out, 1);

        // Reset at RUN cycle 5 abandons the update
        for (int o = 2; o <= 5; o++) begin
            nx_cyc();
            node_in_valid = 1; node_in_x = 16'(4000 + o); node_in_y = 16'(o);
            if (o == 5) rst_in = 1;
        end
        nx_cyc(); rst_in = 0;
        cmp("lit_rst_x3", nodes_out[0][3], 300);
        cmp("lit_rst_busy", busy_out, 0);
        cmp("lit_rst_err", error_out, 0);
        cmp("lit_rst_drop", dropped_out, 0);
        frame(8, 8, 6000, 9, 0);
        nx_cyc();
        cmp("lit_after_rst_fd", frame_done_out, 1);
        cmp("lit_after_rst_x0", nodes_out[0][0], 6000);
        nx_cyc();
        nx_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wheel_state_buffer.md
# wheel_state_buffer

Holds the authoritative per-node position and velocity state of the squishy wheel between physics timesteps, and sequences the wheel updater. On each timestep strobe it pulses the updater's begin and collects the streamed node-position and velocity results into a shadow bank. When the updater signals completion, it commits the shadow bank atomically, so the updater always reads a stable committed state.

## Interface
Parameters:
- NUM_NODES, 8, number of wheel nodes
- POSITION_SIZE, 16, signed position width
- VELOCITY_SIZE, 16, signed velocity width

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  synchronous, active-high reset
- step_in  input  1  one-cycle timestep strobe
- init_nodes  input  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  rest shape; sampled on reset
- node_in_x, node_in_y  input  signed POSITION_SIZE  streamed updated position from the updater
- node_in_valid  input  1  position beat valid
- vel_in_x, vel_in_y  input  signed VELOCITY_SIZE  streamed updated velocity from the updater
- vel_in_valid  input  1  velocity beat valid
- done_in  input  1  updater result_out; one-cycle pulse
- nodes_out  output  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  committed positions; feed the updater nodes_in
- velocities_out  output  signed [VELOCITY_SIZE-1:0] [1:0][NUM_NODES]  committed velocities
- begin_out  output  1  one-cycle start pulse to the updater
- busy_out  output  1  high while an update is in flight
- frame_done_out  output  1  one-cycle pulse on a successful commit
- error_out  output  1  sticky; asserted on a beat-count error
- dropped_out  output  8  saturating count of step_in pulses ignored while busy

## Operation
- States: IDLE, RUN, COMMIT.
- IDLE:
  - On step_in: pulse begin_out, clear node_cnt and vel_cnt, then go to RUN.
  - Valid beats received in IDLE are ignored.
- RUN:
  - Each node_in_valid beat writes shadow_nodes[*][node_cnt] and increments node_cnt.
  - Each vel_in_valid beat does the same on shadow_vel with vel_cnt.
  - The two streams are independent; both may be valid in the same cycle.
  - Beats arriving once a counter equals NUM_NODES are discarded and set the overflow flag.
  - On done_in: go to COMMIT.
  - A beat arriving in the same cycle as done_in is still captured.
- COMMIT (exactly one cycle):
  - Success condition: node_cnt == NUM_NODES, vel_cnt == NUM_NODES, and no overflow. On success, copy both shadow banks to the committed arrays and pulse frame_done_out.
  - Otherwise, leave the committed arrays unchanged and set error_out.
  - Then go to IDLE.
- step_in while in RUN or COMMIT: increment dropped_out, saturating at 255. No queueing.
- Committed arrays change only in the COMMIT cycle. nodes_out and velocities_out are stable for the whole of RUN.
- Counter width: $clog2(NUM_NODES)+1.
- No arithmetic on the data; values are copied bit-exact.

## Timing
- Reset values:
  - State is IDLE.
  - Committed nodes equal init_nodes, sampled during reset.
  - Committed and shadow velocities are 0; shadow nodes are 0.
  - begin_out, busy_out, frame_done_out, error_out are 0; dropped_out is 0.
- Reset asserted mid-RUN: abandons the update; the cycle after rst_in deasserts is IDLE with reset values.
- step_in sampled at cycle t in IDLE: begin_out=1 and busy_out=1 during t+1; begin_out=0 from t+2.
- done_in sampled at cycle d: COMMIT during d+1.
  - Committed outputs and frame_done_out are visible at d+1 (registered on the edge ending cycle d).
  - busy_out=0 at d+2.
  - A step_in at d+2 is accepted.
- busy_out is high from t+1 through d+1 inclusive.
- Minimum step period: 3 cycles plus updater latency.
- error_out clears only on rst_in.

## Test plan
- **Reset load:** set init_nodes x[i]=i*100, y[i]=-i, with NUM_NODES=8, then pulse rst_in. Required: nodes_out equals the init values, velocities_out all 0, all flags 0.
- **Nominal frame:**
  - Stimulus: step_in at cycle 10; 8 node beats x=1000+i; 8 velocity beats vx=-5*i, interleaved with gaps; done_in at cycle 40.
  - Required: begin_out high only at 11. nodes_out and velocities_out unchanged through 40, new values at 41. frame_done_out at 41; busy_out drops at 42.
- **Short stream:** deliver 7 node beats and 8 velocity beats, then done_in. Required: committed state unchanged, error_out=1, frame_done_out stays 0.
- **Overflow:** deliver 9 node beats with the 9th at x=7777. Required: error_out=1, no commit; the 9th value does not appear anywhere.
- **Step while busy:**
  - Stimulus: 3 step_in pulses during RUN; 300 further step_in pulses across later busy windows.
  - Required: dropped_out=3 after the first window, saturating at 255 later; exactly one begin_out per accepted step.
- **Edge cases:**
  - Final node beat and done_in in the same cycle: the beat is captured and the commit succeeds.
  - rst_in at RUN cycle 5: outputs return to reset values, and the next step_in starts cleanly.
